// File: rtl/led_word_presenter.sv
// Buffers 32-bit result words in a small FIFO and steps them onto 16 LEDs as high half, low half, marker.
// Optional LED_PRESENT_REPEAT_EN: the last remaining word is re-displayed instead of popped.
module led_word_presenter #(
    parameter int          DEPTH  = 4,
    parameter logic [15:0] MARKER = 16'hFFFF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [31:0]              in_data,
    output logic                     in_ready,
    input  logic                     step,
    output logic [15:0]              out,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic [1:0]               state_dbg
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, HI = 2'd1, LO = 2'd2, MARK = 2'd3} state_t;

    // Handshake: a word transfers on a rising clk edge where in_valid && in_ready;
    // in_valid may be held across cycles, in_ready depends only on count.
    state_t          state, state_next;
    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr, rd_ptr_inc;
    logic            step_s1, step_s2, step_d, step_pulse;
    logic            push, pop;
    logic [31:0]     head_next;
    logic [15:0]     out_next;

    assign in_ready   = (count < CW'(DEPTH));
    assign push       = in_valid && in_ready;
    assign step_pulse = step_s2 && !step_d;
    assign rd_ptr_inc = rd_ptr + AW'(1);
    assign state_dbg  = state;

    // State register together with the registered LED pattern, busy flag and FIFO bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            out     <= 16'h0000;
            busy    <= 1'b0;
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            step_s1 <= 1'b0;
            step_s2 <= 1'b0;
            step_d  <= 1'b0;
        end else begin
            state   <= state_next;
            out     <= out_next;
            busy    <= (state_next != IDLE);
            step_s1 <= step;
            step_s2 <= step_s1;
            step_d  <= step_s2;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr_inc;
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push)
            mem[wr_ptr] <= in_data;
    end

    // Next-state: the FSM only moves on a conditioned step pulse.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        if (step_pulse) begin
            case (state)
                IDLE: if (count != '0) state_next = HI;
                HI:   state_next = LO;
                LO:   state_next = MARK;
                MARK: begin
`ifdef LED_PRESENT_REPEAT_EN
                    if (count > CW'(1)) begin
                        pop        = 1'b1;
                        state_next = HI;
                    end else begin
                        state_next = HI;
                    end
`else
                    pop        = 1'b1;
                    state_next = (count > CW'(1)) ? HI : IDLE;
`endif
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Output: pattern for the state being entered; a pop exposes the following word as head.
    always_comb begin
        head_next = pop ? mem[rd_ptr_inc] : mem[rd_ptr];
        out_next  = 16'h0000;
        case (state_next)
            HI:      out_next = head_next[31:16];
            LO:      out_next = head_next[15:0];
            MARK:    out_next = MARKER;
            default: out_next = 16'h0000;
        endcase
    end
endmodule

// File: tb/tb_led_word_presenter.sv
// Directed testbench for led_word_presenter with hand-computed expectations.
// Define LED_PRESENT_REPEAT_EN for both files to exercise the repeat mode.
module tb_led_word_presenter;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        step;
    logic [15:0] out;
    logic        busy;
    logic [2:0]  count;
    logic [1:0]  state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    led_word_presenter #(.DEPTH(4), .MARKER(16'hFFFF)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .step(step), .out(out), .busy(busy), .count(count), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One button press: high for one sampled edge, then low; the FSM has moved when this returns.
    task automatic press();
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        tick();
    endtask

    task automatic push_word(input logic [31:0] w);
        in_valid = 1'b1;
        in_data  = w;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        in_valid = 1'b0; in_data = '0; step = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        n_cmp++;
        if (out !== 16'h0000) begin n_err++; $display("FAIL reset_out got %h want 0000", out); end
        n_cmp++;
        if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++;
        if (busy !== 1'b0 || state_dbg !== 2'd0) begin n_err++; $display("FAIL reset_state busy=%b state=%0d want 0/0", busy, state_dbg); end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", in_ready); end
    endtask

    task automatic test_single_word();
        logic [15:0] exp_seq [3];
        exp_seq[0] = 16'hDEAD; exp_seq[1] = 16'hBEEF; exp_seq[2] = 16'hFFFF;
        push_word(32'hDEADBEEF);
        n_cmp++;
        if (count !== 3'd1) begin n_err++; $display("FAIL single_count got %0d want 1", count); end
        for (int i = 0; i < 3; i++) begin
            press();
            n_cmp++;
            if (out !== exp_seq[i] || busy !== 1'b1) begin
                n_err++; $display("FAIL single_frame%0d got %h busy=%b want %h busy=1", i, out, busy, exp_seq[i]);
            end
        end
        press();
        n_cmp++;
        if (out !== 16'h0000 || count !== 3'd0 || busy !== 1'b0) begin
            n_err++; $display("FAIL single_end got out=%h count=%0d busy=%b want 0000/0/0", out, count, busy);
        end
    endtask

    task automatic test_fill();
        in_valid = 1'b1;
        for (int v = 1; v <= 5; v++) begin
            in_data = 32'(v);
            n_cmp++;
            if (in_ready !== (v <= 4)) begin n_err++; $display("FAIL fill_ready%0d got %b want %b", v, in_ready, (v <= 4)); end
            tick();
        end
        n_cmp++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin n_err++; $display("FAIL fill_full got count=%0d ready=%b want 4/0", count, in_ready); end
        for (int i = 0; i < 4; i++) press();
        n_cmp++;
        if (count !== 3'd3 || in_ready !== 1'b1) begin n_err++; $display("FAIL fill_after_pop got count=%0d ready=%b want 3/1", count, in_ready); end
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (count !== 3'd4 || state_dbg !== 2'd1 || out !== 16'h0000) begin
            n_err++; $display("FAIL fill_accept5 got count=%0d state=%0d out=%h want 4/1/0000", count, state_dbg, out);
        end
        for (int w = 2; w <= 5; w++) begin
            press();
            n_cmp++;
            if (out !== 16'(w)) begin n_err++; $display("FAIL drain_lo%0d got %h want %h", w, out, 16'(w)); end
            press();
            press();
            n_cmp++;
            if (w < 5 && (state_dbg !== 2'd1 || out !== 16'h0000)) begin
                n_err++; $display("FAIL drain_hi%0d got state=%0d out=%h want 1/0000", w, state_dbg, out);
            end else if (w == 5 && (state_dbg !== 2'd0 || count !== 3'd0)) begin
                n_err++; $display("FAIL drain_end got state=%0d count=%0d want 0/0", state_dbg, count);
            end
        end
    endtask

    task automatic test_step_hold();
        push_word(32'hA5A50F0F);
        step = 1'b1;
        tick();
        n_cmp++;
        if (out !== 16'h0000) begin n_err++; $display("FAIL hold_t0 got %h want 0000", out); end
        tick();
        n_cmp++;
        if (out !== 16'h0000) begin n_err++; $display("FAIL hold_t1 got %h want 0000", out); end
        tick();
        n_cmp++;
        if (out !== 16'hA5A5) begin n_err++; $display("FAIL hold_t2 got %h want a5a5", out); end
        for (int i = 0; i < 47; i++) tick();
        step = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n_cmp++;
        if (state_dbg !== 2'd1 || out !== 16'hA5A5) begin
            n_err++; $display("FAIL hold_single got state=%0d out=%h want 1/a5a5", state_dbg, out);
        end
        press(); press(); press();
        n_cmp++;
        if (state_dbg !== 2'd0 || count !== 3'd0) begin n_err++; $display("FAIL hold_drain got state=%0d count=%0d want 0/0", state_dbg, count); end
    endtask

    task automatic test_empty_press();
        press();
        n_cmp++;
        if (state_dbg !== 2'd0 || out !== 16'h0000) begin n_err++; $display("FAIL empty_press got state=%0d out=%h want 0/0000", state_dbg, out); end
        // Push lands on the same edge as the pulse: the pulse is lost.
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        in_valid = 1'b1; in_data = 32'hCAFE0001;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (state_dbg !== 2'd0 || count !== 3'd1) begin n_err++; $display("FAIL empty_same_cycle got state=%0d count=%0d want 0/1", state_dbg, count); end
        press();
        n_cmp++;
        if (out !== 16'hCAFE) begin n_err++; $display("FAIL empty_then_push got %h want cafe", out); end
        press(); press(); press();
    endtask

    task automatic test_back_to_back();
        push_word(32'h11112222);
        push_word(32'h33334444);
        press(); press(); press();
        // Pop edge coincides with a push: count must stay at 2.
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        in_valid = 1'b1; in_data = 32'h55556666;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (count !== 3'd2 || out !== 16'h3333) begin n_err++; $display("FAIL b2b_pushpop got count=%0d out=%h want 2/3333", count, out); end
        press();
        n_cmp++;
        if (out !== 16'h4444) begin n_err++; $display("FAIL b2b_lo got %h want 4444", out); end
        press(); press(); press();
        n_cmp++;
        if (out !== 16'h6666) begin n_err++; $display("FAIL b2b_third got %h want 6666", out); end
        press(); press();
        n_cmp++;
        if (state_dbg !== 2'd0 || count !== 3'd0) begin n_err++; $display("FAIL b2b_end got state=%0d count=%0d want 0/0", state_dbg, count); end
    endtask

    task automatic test_reset_mid();
        push_word(32'h0BAD0BAD);
        push_word(32'h0F0F0F0F);
        press(); press();
        n_cmp++;
        if (state_dbg !== 2'd2 || out !== 16'h0BAD) begin n_err++; $display("FAIL mid_lo got state=%0d out=%h want 2/0bad", state_dbg, out); end
        rst = 1'b1; in_valid = 1'b1; in_data = 32'h77777777;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        n_cmp++;
        if (out !== 16'h0000 || count !== 3'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL mid_reset got out=%h count=%0d ready=%b busy=%b want 0000/0/1/0", out, count, in_ready, busy);
        end
    endtask

`ifdef LED_PRESENT_REPEAT_EN
    task automatic test_repeat();
        logic [15:0] exp_seq [6];
        exp_seq[0] = 16'h1234; exp_seq[1] = 16'h5678; exp_seq[2] = 16'hFFFF;
        exp_seq[3] = 16'h1234; exp_seq[4] = 16'h5678; exp_seq[5] = 16'hFFFF;
        push_word(32'h12345678);
        for (int i = 0; i < 6; i++) begin
            press();
            n_cmp++;
            if (out !== exp_seq[i] || count !== 3'd1) begin
                n_err++; $display("FAIL repeat%0d got out=%h count=%0d want %h/1", i, out, count, exp_seq[i]);
            end
        end
        do_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_single_word();
        test_fill();
        test_step_hold();
        test_empty_press();
        test_back_to_back();
        test_reset_mid();
`ifdef LED_PRESENT_REPEAT_EN
        test_repeat();
`endif
        do_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
